parking_lot_controller: RTL and testbench
=========================================

PARKING_LOT_CONTROLLER -- requirements
Module: parking_lot_controller

Interface
REQ-001 The block SHALL have parameter GATE_CYCLES, default 4, giving the number of cycles gate_open is held per accepted request; legal range 1-15.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 enter_req  input  1  level; a car at the entry gate requests a space.
REQ-005 exit_req  input  1  level; a car at the exit gate requests release of space exit_number.
REQ-006 exit_number  input  3  index of the space being vacated; sampled only with exit_req.
REQ-007 park_number  output  3  registered index of the last allocated or released space; feeds the downstream exit decoder.
REQ-008 park_valid  output  1  one-cycle pulse; park_number is newly updated.
REQ-009 enter_ack / exit_ack  output  1 each  one-cycle pulse; request accepted.
REQ-010 enter_err / exit_err  output  1 each  one-cycle pulse; request rejected.
REQ-011 gate_open  output  1  high while the gate is held open.
REQ-012 occupancy  output  8  bit i high = space i occupied.
REQ-013 free_count  output  4  number of free spaces, 0-8.
REQ-014 full / empty  output  1 each  free_count==0 / free_count==8.
REQ-015 total_entries  output  16  accepted-entry count (see Configuration).

Function
REQ-016 The FSM SHALL have states IDLE and GATE; requests SHALL be sampled only in IDLE.
REQ-017 In IDLE with exit_req=1: if occupancy[exit_number]=1, that bit SHALL clear, park_number<=exit_number, and exit_ack and park_valid SHALL pulse in the next cycle, FSM->GATE; otherwise exit_err SHALL pulse in the next cycle, FSM stays IDLE, no state change.
REQ-018 In IDLE with enter_req=1 and exit_req=0: if not full, the lowest-index free space SHALL be set occupied, park_number<=that index, and enter_ack and park_valid SHALL pulse in the next cycle, FSM->GATE; if full, enter_err SHALL pulse in the next cycle, FSM stays IDLE.
REQ-019 Simultaneous enter_req and exit_req in IDLE: exit SHALL be served; enter remains pending and is served on a later IDLE cycle if still asserted.
REQ-020 GATE SHALL last exactly GATE_CYCLES cycles, with gate_open=1 throughout, and then return to IDLE; requests during GATE SHALL be ignored (no ack, no err).
REQ-021 Latency: request sampled in IDLE cycle t -> ack/err/park_valid high in cycle t+1; gate_open high in cycles t+1 through t+GATE_CYCLES.
REQ-022 free_count SHALL equal 8 minus the popcount of occupancy at all times, be registered, and never wrap.
REQ-023 At most one of enter_ack, exit_ack, enter_err, and exit_err SHALL be high in any cycle.
REQ-024 park_number SHALL hold its value between updates; an error SHALL NOT change it.

Reset
REQ-025 rst=1 at a clock edge SHALL force FSM=IDLE, occupancy=0, free_count=8, empty=1, full=0, park_number=0, total_entries=0, and all pulses and gate_open=0, including mid-GATE.
REQ-026 A request held through reset release SHALL be sampled on the first edge with rst=0.

Configuration
REQ-027 With macro PARKING_STATS_EN defined, total_entries SHALL increment by 1 on each enter_ack and saturate at 16'hFFFF.
REQ-028 Without PARKING_STATS_EN, the total_entries port SHALL exist, be driven constant 0, and contain no counter logic.

Verification
REQ-029 After reset, pulse enter_req 3 times (waiting for gate close each time) -> park_number 0,1,2; occupancy=8'h07; free_count=5.
REQ-030 occupancy=8'h07, exit_req with exit_number=1 -> exit_ack, park_number=1, occupancy=8'h05; next enter -> park_number=1.
REQ-031 Fill all 8 spaces, then enter_req -> enter_err, full=1, occupancy=8'hFF unchanged; exit_number=5 on an empty space (after clearing it) -> exit_err.
REQ-032 occupancy=8'h01, enter_req and exit_req(0) together -> exit_ack first, occupancy=8'h00, then enter_ack with park_number=0 after GATE_CYCLES+1 cycles.
REQ-033 Assert rst during cycle 2 of GATE with occupancy=8'h03 -> next cycle gate_open=0, occupancy=0, free_count=8, empty=1.
REQ-034 With PARKING_STATS_EN, 10 accepted entries interleaved with exits -> total_entries=10; without the macro -> total_entries=0.

Source files
------------

// File: rtl/parking_lot_controller.sv
// ============================================================================
// parking_lot_controller
// ----------------------------------------------------------------------------
// Eight-space parking lot controller. Cars request entry or exit; the block
// allocates the lowest-index free space on entry, releases a named space on
// exit, and holds the gate open for GATE_CYCLES cycles after each accepted
// request. Requests are only looked at while the gate is closed (IDLE).
//
// Optional feature macro: PARKING_STATS_EN
//   defined   -> total_entries counts accepted entries, saturating at 16'hFFFF
//   undefined -> total_entries is tied to zero, no counter is built
//
// Parameters
//   GATE_CYCLES   cycles gate_open stays high per accepted request (1..15)
//
// Ports
//   clk            in   single clock, rising edge
//   rst            in   synchronous active-high reset
//   enter_req      in   level, car at entry gate wants a space
//   exit_req       in   level, car at exit gate releases exit_number
//   exit_number    in   [2:0] space being vacated (used only with exit_req)
//   park_number    out  [2:0] last allocated/released space (registered)
//   park_valid     out  one-cycle pulse, park_number just updated
//   enter_ack      out  one-cycle pulse, entry accepted
//   exit_ack       out  one-cycle pulse, exit accepted
//   enter_err      out  one-cycle pulse, entry rejected (lot full)
//   exit_err       out  one-cycle pulse, exit rejected (space not occupied)
//   gate_open      out  high while the gate is held open
//   occupancy      out  [7:0] bit i set = space i occupied
//   free_count     out  [3:0] number of free spaces, 0..8 (registered)
//   full           out  free_count == 0
//   empty          out  free_count == 8
//   total_entries  out  [15:0] accepted-entry count (see macro above)
// ============================================================================
module parking_lot_controller #(
    parameter int unsigned GATE_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enter_req,
    input  logic        exit_req,
    input  logic [2:0]  exit_number,
    output logic [2:0]  park_number,
    output logic        park_valid,
    output logic        enter_ack,
    output logic        exit_ack,
    output logic        enter_err,
    output logic        exit_err,
    output logic        gate_open,
    output logic [7:0]  occupancy,
    output logic [3:0]  free_count,
    output logic        full,
    output logic        empty,
    output logic [15:0] total_entries
);

    // ------------------------------------------------------------------
    // FSM encoding
    // ------------------------------------------------------------------
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_GATE = 1'b1;

    // Gate counter is loaded with GATE_CYCLES-1 on entry to GATE and the
    // FSM leaves GATE on the edge where it reads zero, giving exactly
    // GATE_CYCLES cycles with gate_open high.
    localparam logic [3:0] GATE_LOAD = 4'(GATE_CYCLES - 1);

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    logic [0:0] state_q,     state_d;
    logic [3:0] cnt_q,       cnt_d;
    logic [7:0] occ_q,       occ_d;
    logic [3:0] free_q,      free_d;
    logic [2:0] park_q,      park_d;
    logic       valid_q,     valid_d;
    logic       enter_ack_q, enter_ack_d;
    logic       exit_ack_q,  exit_ack_d;
    logic       enter_err_q, enter_err_d;
    logic       exit_err_q,  exit_err_d;

    // ------------------------------------------------------------------
    // Lowest-index free space search
    // ------------------------------------------------------------------
    logic [2:0] free_idx;
    logic       free_found;

    always_comb begin
        free_idx   = '0;
        free_found = 1'b0;
        for (int unsigned i = 0; i < 8; i++) begin
            if (!occ_q[i] && !free_found) begin
                free_idx   = 3'(i);
                free_found = 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        occ_d       = occ_q;
        free_d      = free_q;
        park_d      = park_q;
        valid_d     = 1'b0;
        enter_ack_d = 1'b0;
        exit_ack_d  = 1'b0;
        enter_err_d = 1'b0;
        exit_err_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // Exit has priority; a concurrent entry simply stays pending
                // and is looked at again on the next IDLE cycle.
                if (exit_req) begin
                    if (occ_q[exit_number]) begin
                        occ_d[exit_number] = 1'b0;
                        free_d             = free_q + 4'd1;
                        park_d             = exit_number;
                        valid_d            = 1'b1;
                        exit_ack_d         = 1'b1;
                        state_d            = ST_GATE;
                        cnt_d              = GATE_LOAD;
                    end else begin
                        exit_err_d = 1'b1;
                    end
                end else if (enter_req) begin
                    if (free_found) begin
                        occ_d[free_idx] = 1'b1;
                        free_d          = free_q - 4'd1;
                        park_d          = free_idx;
                        valid_d         = 1'b1;
                        enter_ack_d     = 1'b1;
                        state_d         = ST_GATE;
                        cnt_d           = GATE_LOAD;
                    end else begin
                        enter_err_d = 1'b1;
                    end
                end
            end

            ST_GATE: begin
                // Requests are ignored while the gate is open.
                if (cnt_q == 4'd0) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Sequential state
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            occ_q       <= '0;
            free_q      <= 4'd8;
            park_q      <= '0;
            valid_q     <= 1'b0;
            enter_ack_q <= 1'b0;
            exit_ack_q  <= 1'b0;
            enter_err_q <= 1'b0;
            exit_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            occ_q       <= occ_d;
            free_q      <= free_d;
            park_q      <= park_d;
            valid_q     <= valid_d;
            enter_ack_q <= enter_ack_d;
            exit_ack_q  <= exit_ack_d;
            enter_err_q <= enter_err_d;
            exit_err_q  <= exit_err_d;
        end
    end

    // ------------------------------------------------------------------
    // Entry statistics
    // ------------------------------------------------------------------
`ifdef PARKING_STATS_EN
    logic [15:0] entries_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            entries_q <= '0;
        end else if (enter_ack_d && (entries_q != '1)) begin
            entries_q <= entries_q + 16'd1;
        end
    end

    assign total_entries = entries_q;
`else
    assign total_entries = '0;
`endif

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign park_number = park_q;
    assign park_valid  = valid_q;
    assign enter_ack   = enter_ack_q;
    assign exit_ack    = exit_ack_q;
    assign enter_err   = enter_err_q;
    assign exit_err    = exit_err_q;
    assign gate_open   = (state_q == ST_GATE);
    assign occupancy   = occ_q;
    assign free_count  = free_q;
    assign full        = (free_q == 4'd0);
    assign empty       = (free_q == 4'd8);

endmodule

// File: tb/tb_parking_lot_controller.sv
// ============================================================================
// tb_parking_lot_controller
// ----------------------------------------------------------------------------
// Directed scenarios followed by random traffic, every cycle compared against
// a behavioural model of the lot (array of spaces, remaining gate time).
// Honours PARKING_STATS_EN for the expected total_entries value.
// ============================================================================
module tb_parking_lot_controller;

    localparam int GC = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enter_req = 1'b0;
    logic        exit_req = 1'b0;
    logic [2:0]  exit_number = '0;
    logic [2:0]  park_number;
    logic        park_valid;
    logic        enter_ack;
    logic        exit_ack;
    logic        enter_err;
    logic        exit_err;
    logic        gate_open;
    logic [7:0]  occupancy;
    logic [3:0]  free_count;
    logic        full;
    logic        empty;
    logic [15:0] total_entries;

    int total = 0;
    int bad   = 0;

    // behavioural model state
    bit m_occ[8];
    int m_busy;
    int m_park;
    int m_entries;
    bit m_pv, m_ea, m_xa, m_ee, m_xe;

    parking_lot_controller #(.GATE_CYCLES(GC)) dut (
        .clk           (clk),
        .rst           (rst),
        .enter_req     (enter_req),
        .exit_req      (exit_req),
        .exit_number   (exit_number),
        .park_number   (park_number),
        .park_valid    (park_valid),
        .enter_ack     (enter_ack),
        .exit_ack      (exit_ack),
        .enter_err     (enter_err),
        .exit_err      (exit_err),
        .gate_open     (gate_open),
        .occupancy     (occupancy),
        .free_count    (free_count),
        .full          (full),
        .empty         (empty),
        .total_entries (total_entries)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int m_used();
        int n = 0;
        for (int i = 0; i < 8; i++) n += int'(m_occ[i]);
        return n;
    endfunction

    function automatic int m_occ_word();
        int w = 0;
        for (int i = 0; i < 8; i++) if (m_occ[i]) w += (1 << i);
        return w;
    endfunction

    function automatic int m_total();
`ifdef PARKING_STATS_EN
        return (m_entries > 65535) ? 65535 : m_entries;
`else
        return 0;
`endif
    endfunction

    // model reaction to one clock edge with the given inputs
    task automatic model_edge(input bit r, input bit en, input bit ex, input int num);
        m_pv = 0; m_ea = 0; m_xa = 0; m_ee = 0; m_xe = 0;
        if (r) begin
            for (int i = 0; i < 8; i++) m_occ[i] = 0;
            m_busy = 0; m_park = 0; m_entries = 0;
        end else if (m_busy > 0) begin
            m_busy--;
        end else if (ex) begin
            if (m_occ[num]) begin
                m_occ[num] = 0; m_park = num; m_xa = 1; m_pv = 1; m_busy = GC;
            end else begin
                m_xe = 1;
            end
        end else if (en) begin
            int k = -1;
            for (int i = 7; i >= 0; i--) if (!m_occ[i]) k = i;
            if (k >= 0) begin
                m_occ[k] = 1; m_park = k; m_ea = 1; m_pv = 1; m_busy = GC; m_entries++;
            end else begin
                m_ee = 1;
            end
        end
    endtask

    task automatic check_all();
        chk("park_number", int'(park_number), m_park);
        chk("park_valid", int'(park_valid), int'(m_pv));
        chk("enter_ack", int'(enter_ack), int'(m_ea));
        chk("exit_ack", int'(exit_ack), int'(m_xa));
        chk("enter_err", int'(enter_err), int'(m_ee));
        chk("exit_err", int'(exit_err), int'(m_xe));
        chk("gate_open", int'(gate_open), int'(m_busy > 0));
        chk("occupancy", int'(occupancy), m_occ_word());
        chk("free_count", int'(free_count), 8 - m_used());
        chk("full", int'(full), int'(m_used() == 8));
        chk("empty", int'(empty), int'(m_used() == 0));
        chk("total_entries", int'(total_entries), m_total());
        chk("pulse_onehot", int'($countones({enter_ack, exit_ack, enter_err, exit_err}) <= 1), 1);
    endtask

    // one clock: drive inputs, take the edge, sample 1 time unit later
    task automatic cyc(input bit r, input bit en, input bit ex, input int num);
        rst = r; enter_req = en; exit_req = ex; exit_number = 3'(num);
        @(posedge clk);
        model_edge(r, en, ex, num);
        #1;
        check_all();
    endtask

    task automatic idle(input int n);
        repeat (n) cyc(0, 0, 0, 0);
    endtask

    initial begin
        m_busy = 0; m_park = 0; m_entries = 0;
        #1;

        // reset state
        cyc(1, 0, 0, 0);
        cyc(1, 0, 0, 0);
        chk("rst_free", int'(free_count), 8);
        chk("rst_empty", int'(empty), 1);
        chk("rst_gate", int'(gate_open), 0);

        // three entries -> spaces 0,1,2
        for (int i = 0; i < 3; i++) begin
            cyc(0, 1, 0, 0);
            chk("seq_park", int'(park_number), i);
            idle(GC);
        end
        chk("seq_occ", int'(occupancy), 'h07);
        chk("seq_free", int'(free_count), 5);

        // release space 1, next entry reuses it
        cyc(0, 0, 1, 1);
        chk("rel_ack", int'(exit_ack), 1);
        chk("rel_park", int'(park_number), 1);
        chk("rel_occ", int'(occupancy), 'h05);
        idle(GC);
        cyc(0, 1, 0, 0);
        chk("reuse_park", int'(park_number), 1);
        idle(GC);

        // fill the lot, then reject an entry
        repeat (5) begin
            cyc(0, 1, 0, 0);
            idle(GC);
        end
        chk("fill_occ", int'(occupancy), 'hFF);
        cyc(0, 1, 0, 0);
        chk("full_err", int'(enter_err), 1);
        chk("full_flag", int'(full), 1);
        chk("full_occ", int'(occupancy), 'hFF);

        // empty space 5 then try to release it again
        cyc(0, 0, 1, 5);
        idle(GC);
        cyc(0, 0, 1, 5);
        chk("bad_exit_err", int'(exit_err), 1);
        chk("bad_exit_park", int'(park_number), 5);

        // simultaneous enter/exit: exit first, enter after the gate
        cyc(1, 0, 0, 0);
        cyc(0, 1, 0, 0);
        idle(GC);
        cyc(0, 1, 1, 0);
        chk("both_exit_ack", int'(exit_ack), 1);
        chk("both_occ", int'(occupancy), 0);
        repeat (GC) cyc(0, 1, 0, 0);
        cyc(0, 1, 0, 0);
        chk("pend_enter_ack", int'(enter_ack), 1);
        chk("pend_park", int'(park_number), 0);
        idle(GC);

        // reset in the second cycle of GATE
        cyc(1, 0, 0, 0);
        cyc(0, 1, 0, 0);
        idle(GC);
        cyc(0, 1, 0, 0);
        cyc(0, 0, 0, 0);
        cyc(1, 0, 0, 0);
        chk("midgate_gate", int'(gate_open), 0);
        chk("midgate_occ", int'(occupancy), 0);
        chk("midgate_free", int'(free_count), 8);
        chk("midgate_empty", int'(empty), 1);

        // request held through reset release
        cyc(1, 1, 0, 0);
        cyc(0, 1, 0, 0);
        chk("post_rst_ack", int'(enter_ack), 1);
        idle(GC);

        // ten entries interleaved with exits
        cyc(1, 0, 0, 0);
        repeat (10) begin
            cyc(0, 1, 0, 0);
            idle(GC);
            cyc(0, 0, 1, 0);
            idle(GC);
        end
`ifdef PARKING_STATS_EN
        chk("stats_total", int'(total_entries), 10);
`else
        chk("stats_total", int'(total_entries), 0);
`endif

        // random traffic
        for (int n = 0; n < 800; n++) begin
            cyc(bit'($urandom_range(0, 99) == 0),
                bit'($urandom_range(0, 99) < 60),
                bit'($urandom_range(0, 99) < 25),
                int'($urandom_range(0, 7)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
